// File: rtl/redirect_pkg.sv
// -----------------------------------------------------------------------------
// redirect_pkg
//   Shared types for the redirect scheduler: FSM state encoding, redirect
//   source tag and the held-request record (target address + source).
//   REDIR_ADDR_W matches the core instruction address width. The scheduler's
//   ADDR_W parameter is expected not to exceed it.
// -----------------------------------------------------------------------------
package redirect_pkg;

    localparam int REDIR_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ATOM = 2'd1,
        ISSUE     = 2'd2,
        FLUSH     = 2'd3
    } redir_state_e;

    typedef enum logic {
        SRC_EX    = 1'b0,
        SRC_CLINT = 1'b1
    } redir_src_e;

    typedef struct packed {
        logic [REDIR_ADDR_W-1:0] addr;
        redir_src_e              src;
    } redir_req_t;

endpackage

// File: rtl/redirect_perf_cnt.sv
// -----------------------------------------------------------------------------
// redirect_perf_cnt
//   Two free-running, wrapping event counters for the redirect scheduler.
//   Ports:
//     clk, rst   clock, synchronous active-high reset (counters clear to 0)
//     transfer   one redirect accepted by pc_reg this cycle
//     hold       a redirect is being held back this cycle (atomic or stall/no-ack)
//     redir_cnt  number of accepted redirects
//     hold_cnt   number of held cycles
// -----------------------------------------------------------------------------
module redirect_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             transfer,
    input  logic             hold,
    output logic [CNT_W-1:0] redir_cnt,
    output logic [CNT_W-1:0] hold_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            redir_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            if (transfer) redir_cnt <= redir_cnt + CNT_W'(1);
            if (hold)     hold_cnt  <= hold_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/redirect_sched.sv
// -----------------------------------------------------------------------------
// redirect_sched
//   Captures control-flow redirects from EX (branch/jump) and CLINT
//   (trap/mret), arbitrates them (CLINT wins), waits out in-flight atomic
//   ops, presents one redirect to pc_reg with a valid/ack handshake, then
//   drives a fixed-length IF/ID flush window.
//
//   Handshake: redir_valid_o/redir_addr_o are held stable until a transfer,
//   defined as redir_valid_o & redir_ack_i & ~stall_i in the same cycle.
//   Valid never drops before transfer. The only permitted change while
//   valid is high is a CLINT request overriding a held EX target.
//
//   Optional feature macro: REDIRECT_PERF_CNT_EN
//     defined   -> redir_cnt_o / hold_cnt_o count transfers / held cycles
//     undefined -> both ports tie to 0 and no counter flops exist
//
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     ex_req_i/addr     EX redirect request pulse and target
//     clint_req_i/addr  CLINT redirect request pulse and target
//     atom_busy_i       atomic op in flight, redirect must not issue
//     stall_i           pipeline stall, blocks transfer
//     redir_valid_o     redirect presented to pc_reg
//     redir_addr_o      redirect target (0 when not valid)
//     redir_ack_i       pc_reg accepts redirect
//     flush_o           flush IF/ID stages
//     busy_o            scheduler not idle (state or pending slot)
//     redir_cnt_o       redirects issued (macro only)
//     hold_cnt_o        cycles redirect held (macro only)
// -----------------------------------------------------------------------------
module redirect_sched
    import redirect_pkg::*;
#(
    parameter int ADDR_W       = REDIR_ADDR_W,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_req_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic              clint_req_i,
    input  logic [ADDR_W-1:0] clint_addr_i,
    input  logic              atom_busy_i,
    input  logic              stall_i,
    output logic              redir_valid_o,
    output logic [ADDR_W-1:0] redir_addr_o,
    input  logic              redir_ack_i,
    output logic              flush_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  redir_cnt_o,
    output logic [CNT_W-1:0]  hold_cnt_o
);

    localparam int              CW         = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0]   FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);

    redir_state_e  state_q, state_d;
    redir_req_t    held_q, held_d;
    redir_req_t    pend_q, pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;

    redir_req_t    in_req;
    redir_req_t    clint_req;
    redir_req_t    slot;
    logic          slot_valid;
    logic          transfer;

    // Incoming request after same-cycle arbitration: CLINT beats EX.
    always_comb begin
        clint_req.addr = REDIR_ADDR_W'(clint_addr_i);
        clint_req.src  = SRC_CLINT;
        in_req.addr    = clint_req_i ? REDIR_ADDR_W'(clint_addr_i) : REDIR_ADDR_W'(ex_addr_i);
        in_req.src     = clint_req_i ? SRC_CLINT : SRC_EX;
    end

    assign transfer = (state_q == ISSUE) & redir_ack_i & ~stall_i;

    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        flush_cnt_d  = flush_cnt_q;

        // Pending-slot merge used during FLUSH: a CLINT request takes an
        // empty or EX-occupied slot; an EX request only takes an empty slot.
        slot       = pend_q;
        slot_valid = pend_valid_q;
        if (clint_req_i && (!pend_valid_q || pend_q.src == SRC_EX)) begin
            slot       = clint_req;
            slot_valid = 1'b1;
        end else if (ex_req_i && !pend_valid_q) begin
            slot       = in_req;
            slot_valid = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (ex_req_i || clint_req_i) begin
                    held_d  = in_req;
                    state_d = atom_busy_i ? WAIT_ATOM : ISSUE;
                end
            end
            WAIT_ATOM: begin
                // EX requests here are from a squashed younger path: dropped.
                if (clint_req_i && held_q.src == SRC_EX) held_d = clint_req;
                if (!atom_busy_i) state_d = ISSUE;
            end
            ISSUE: begin
                if (transfer) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                    // The slot is always empty on entry to FLUSH.
                    if (clint_req_i) begin
                        pend_d       = clint_req;
                        pend_valid_d = 1'b1;
                    end
                end else if (clint_req_i && held_q.src == SRC_EX) begin
                    held_d = clint_req;
                end
            end
            FLUSH: begin
                pend_d       = slot;
                pend_valid_d = slot_valid;
                if (flush_cnt_q == '0) begin
                    // Chain straight into the next redirect, no IDLE bubble.
                    if (slot_valid) begin
                        held_d       = slot;
                        pend_valid_d = 1'b0;
                        state_d      = atom_busy_i ? WAIT_ATOM : ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    flush_cnt_d = flush_cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            held_q       <= '{addr: '0, src: SRC_EX};
            pend_q       <= '{addr: '0, src: SRC_EX};
            pend_valid_q <= 1'b0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign redir_valid_o = (state_q == ISSUE);
    assign redir_addr_o  = redir_valid_o ? ADDR_W'(held_q.addr) : '0;
    assign flush_o       = (state_q == FLUSH);
    assign busy_o        = (state_q != IDLE) | pend_valid_q;

`ifdef REDIRECT_PERF_CNT_EN
    logic hold;
    assign hold = (state_q == WAIT_ATOM) |
                  ((state_q == ISSUE) & (stall_i | ~redir_ack_i));

    redirect_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk       (clk),
        .rst       (rst),
        .transfer  (transfer),
        .hold      (hold),
        .redir_cnt (redir_cnt_o),
        .hold_cnt  (hold_cnt_o)
    );
`else
    assign redir_cnt_o = '0;
    assign hold_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_redirect_sched.sv
module tb_redirect_sched;

  localparam int ADDR_W       = 32;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              ex_req_i, clint_req_i, atom_busy_i, stall_i, redir_ack_i;
  logic [ADDR_W-1:0] ex_addr_i, clint_addr_i;
  logic              redir_valid_o, flush_o, busy_o;
  logic [ADDR_W-1:0] redir_addr_o;
  logic [CNT_W-1:0]  redir_cnt_o, hold_cnt_o;

  redirect_sched #(
    .ADDR_W       (ADDR_W),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_req_i      (ex_req_i),
    .ex_addr_i     (ex_addr_i),
    .clint_req_i   (clint_req_i),
    .clint_addr_i  (clint_addr_i),
    .atom_busy_i   (atom_busy_i),
    .stall_i       (stall_i),
    .redir_valid_o (redir_valid_o),
    .redir_addr_o  (redir_addr_o),
    .redir_ack_i   (redir_ack_i),
    .flush_o       (flush_o),
    .busy_o        (busy_o),
    .redir_cnt_o   (redir_cnt_o),
    .hold_cnt_o    (hold_cnt_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: "a redirect is held" (maybe waiting on an atomic),
  // "flush cycles still to show", and a one-entry pending record.
  bit              m_held, m_wait, m_clint;
  logic [31:0]     m_addr;
  int              m_flush_left;
  bit              m_pend, m_pend_clint;
  logic [31:0]     m_pend_addr;
  logic [CNT_W-1:0] m_redir_cnt, m_hold_cnt;

  task automatic model_reset();
    m_held = 0; m_wait = 0; m_clint = 0; m_addr = '0;
    m_flush_left = 0;
    m_pend = 0; m_pend_clint = 0; m_pend_addr = '0;
    m_redir_cnt = '0; m_hold_cnt = '0;
  endtask

  task automatic model_step(input bit r, input bit ex, input logic [31:0] ea,
                            input bit cl, input logic [31:0] ca,
                            input bit atom, input bit stall, input bit ack);
    if (r) begin
      model_reset();
      return;
    end
    if (m_flush_left > 0) begin
      if (cl && (!m_pend || !m_pend_clint)) begin
        m_pend = 1; m_pend_addr = ca; m_pend_clint = 1;
      end else if (ex && !m_pend) begin
        m_pend = 1; m_pend_addr = ea; m_pend_clint = 0;
      end
      m_flush_left--;
      if (m_flush_left == 0 && m_pend) begin
        m_held = 1; m_addr = m_pend_addr; m_clint = m_pend_clint;
        m_wait = atom; m_pend = 0;
      end
    end else if (m_held && m_wait) begin
      m_hold_cnt++;
      if (cl && !m_clint) begin m_addr = ca; m_clint = 1; end
      if (!atom) m_wait = 0;
    end else if (m_held) begin
      if (ack && !stall) begin
        m_redir_cnt++;
        exp_q.push_back(m_addr);
        m_held = 0;
        m_flush_left = FLUSH_CYCLES;
        if (cl) begin m_pend = 1; m_pend_addr = ca; m_pend_clint = 1; end
      end else begin
        m_hold_cnt++;
        if (cl && !m_clint) begin m_addr = ca; m_clint = 1; end
      end
    end else if (ex || cl) begin
      m_held = 1; m_addr = cl ? ca : ea; m_clint = cl; m_wait = atom;
    end
  endtask

  task automatic check_outputs();
    bit exp_valid;
    exp_valid = m_held && !m_wait;
    check("valid", redir_valid_o, exp_valid);
    check("addr",  redir_addr_o, exp_valid ? m_addr : 32'h0);
    check("flush", flush_o, m_flush_left > 0);
    check("busy",  busy_o, m_held || m_flush_left > 0 || m_pend);
`ifdef REDIRECT_PERF_CNT_EN
    check("redir_cnt", redir_cnt_o, m_redir_cnt);
    check("hold_cnt",  hold_cnt_o,  m_hold_cnt);
`else
    check("redir_cnt", redir_cnt_o, 0);
    check("hold_cnt",  hold_cnt_o,  0);
`endif
  endtask

  // ---------------- driver ----------------
  // One clock: drive after the edge, check at the falling edge, then
  // advance the model with the inputs the DUT will sample next edge.
  task automatic cycle(input bit r, input bit ex, input logic [31:0] ea,
                       input bit cl, input logic [31:0] ca,
                       input bit atom, input bit stall, input bit ack);
    bit dut_xfer;
    logic [ADDR_W-1:0] dut_addr;
    @(posedge clk);
    #1;
    rst = r; ex_req_i = ex; ex_addr_i = ea; clint_req_i = cl; clint_addr_i = ca;
    atom_busy_i = atom; stall_i = stall; redir_ack_i = ack;
    @(negedge clk);
    check_outputs();
    dut_xfer = !r && (redir_valid_o === 1'b1) && ack && !stall;
    dut_addr = redir_addr_o;
    model_step(r, ex, ea, cl, ca, atom, stall, ack);
    if (dut_xfer) begin
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("xfer_addr", dut_addr, exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, ack);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int atom_left;
    rst = 1; ex_req_i = 0; ex_addr_i = 0; clint_req_i = 0; clint_addr_i = 0;
    atom_busy_i = 0; stall_i = 0; redir_ack_i = 0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state
    idle(2, 1);
    check("rst_valid", redir_valid_o, 0);
    check("rst_busy",  busy_o, 0);

    // 1: basic EX redirect with immediate ack
    cycle(0, 1, 32'h8000_0100, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check("t1_valid", redir_valid_o, 1);
    check("t1_addr",  redir_addr_o, 32'h8000_0100);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check("t1_flush2", flush_o, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check("t1_flush3", flush_o, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check("t1_busy4", busy_o, 0);

    // 2: stall holds valid for 5 cycles, transfer on first unstalled cycle
    cycle(0, 1, 32'h0000_4440, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 1, 1);
      check("t2_hold_addr", redir_addr_o, 32'h0000_4440);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check("t2_flush", flush_o, 1);
    idle(2, 1);

    // 3: atomic in flight for 3 cycles at request time
    cycle(0, 1, 32'h0000_1230, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check("t3_wait_valid", redir_valid_o, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check("t3_valid", redir_valid_o, 1);
    idle(3, 1);

    // 4: same-cycle EX and CLINT, CLINT wins
    cycle(0, 1, 32'h0000_0100, 1, 32'h0000_0200, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check("t4_addr", redir_addr_o, 32'h0000_0200);
    idle(3, 1);

    // 5: CLINT during FLUSH is issued right after the window
    cycle(0, 1, 32'h0000_0300, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 32'h0000_0500, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_flush", flush_o, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check("t5_chain_valid", redir_valid_o, 1);
    check("t5_chain_addr",  redir_addr_o, 32'h0000_0500);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check("t5_flush_again", flush_o, 1);
    idle(3, 1);

    // 6: reset mid-ISSUE loses the held redirect
    cycle(0, 1, 32'h0000_0600, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check("t6_valid", redir_valid_o, 0);
    check("t6_busy",  busy_o, 0);
    idle(2, 1);

    // Random phase
    atom_left = 0;
    for (int i = 0; i < 1500; i++) begin
      bit r, ex, cl, atom, stall, ack;
      logic [31:0] ea, ca;
      r     = ($urandom_range(0, 199) == 0);
      ex    = ($urandom_range(0, 5) == 0);
      cl    = ($urandom_range(0, 9) == 0);
      ea    = $urandom() & 32'hFFFF_FFFC;
      ca    = $urandom() & 32'hFFFF_FFFC;
      if (atom_left == 0 && $urandom_range(0, 11) == 0) atom_left = $urandom_range(1, 5);
      atom  = (atom_left > 0);
      if (atom_left > 0) atom_left--;
      stall = ($urandom_range(0, 3) == 0);
      ack   = r ? 1'b0 : ($urandom_range(0, 3) != 0);
      cycle(r, ex, ea, cl, ca, atom, stall, ack);
    end

    idle(12, 1);
    check("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
